// File: rtl/regfile_writeback_queue.sv
// Buffers {reg, data} results and drains one per cycle into the register-file write port.
// Latency: push at edge N into an empty queue -> reg_write high N+1..N+2 (no fall-through).
// Backpressure: in_ready = count < DEPTH from registered count; write_hold pauses draining only.
module regfile_writeback_queue #(
    parameter int DATA_WIDTH       = 24,
    parameter int ADDR_WIDTH       = 2,
    parameter int DEPTH            = 4,
    parameter int ZERO_REG_DISCARD = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_WIDTH-1:0]         in_reg,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          write_hold,
    output logic                          reg_write,
    output logic [ADDR_WIDTH-1:0]         write_reg,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic [(2**ADDR_WIDTH)-1:0]    pending,
    input  logic [ADDR_WIDTH-1:0]         lookup_reg_1,
    input  logic [ADDR_WIDTH-1:0]         lookup_reg_2,
    output logic                          bypass_hit_1,
    output logic                          bypass_hit_2,
    output logic [DATA_WIDTH-1:0]         bypass_data_1,
    output logic [DATA_WIDTH-1:0]         bypass_data_2
);
    localparam int NUM_REGS = 2**ADDR_WIDTH;
    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;

    logic [ADDR_WIDTH-1:0] reg_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         wptr_q;
    logic [PW-1:0]         rptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  reg_write_q;
    logic [ADDR_WIDTH-1:0] write_reg_q;
    logic [DATA_WIDTH-1:0] write_data_q;

    logic                  push_acc;
    logic                  enq;
    logic                  pop;
    logic [NUM_REGS-1:0]   pending_c;
    logic [DATA_WIDTH-1:0] byp1_c;
    logic [DATA_WIDTH-1:0] byp2_c;
    logic [PW-1:0]         idx;

    // Gated with reset_n so the producer sees no handshake while reset is held.
    assign in_ready = reset_n & (count_q < CW'(DEPTH));
    assign push_acc = in_valid & in_ready;
    assign enq      = push_acc & ~((ZERO_REG_DISCARD != 0) && (in_reg == '0));
    assign pop      = (count_q != '0) & ~write_hold;

    always_comb begin
        count_d = count_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            count_q     <= count_d;
            reg_write_q <= pop;
            if (enq) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q       <= rptr_q + 1'b1;
                write_reg_q  <= reg_q[rptr_q];
                write_data_q <= data_q[rptr_q];
            end
        end
    end

    // Storage needs no reset: entries are only observed inside the valid window.
    always_ff @(posedge clock) begin
        if (enq) begin
            reg_q[wptr_q]  <= in_reg;
            data_q[wptr_q] <= in_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest value.
    always_comb begin
        pending_c = '0;
        byp1_c    = '0;
        byp2_c    = '0;
        idx       = '0;
        if (reg_write_q) begin
            pending_c[write_reg_q] = 1'b1;
            if (write_reg_q == lookup_reg_1) byp1_c = write_data_q;
            if (write_reg_q == lookup_reg_2) byp2_c = write_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                pending_c[reg_q[idx]] = 1'b1;
                if (reg_q[idx] == lookup_reg_1) byp1_c = data_q[idx];
                if (reg_q[idx] == lookup_reg_2) byp2_c = data_q[idx];
            end
        end
    end

    assign pending       = pending_c;
    assign bypass_hit_1  = pending_c[lookup_reg_1];
    assign bypass_hit_2  = pending_c[lookup_reg_2];
    assign bypass_data_1 = byp1_c;
    assign bypass_data_2 = byp2_c;
    assign reg_write     = reg_write_q;
    assign write_reg     = write_reg_q;
    assign write_data    = write_data_q;
    assign count         = count_q;

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Initiator for the register file write port. Drives reg_write / write_reg / write_data from a queue of completed results.
- Upstream producers (ALU, load unit) push {destination, data} with a valid/ready handshake. The block buffers the pushes and drains at most one per cycle into the register file.
- Exposes a per-register pending mask and a youngest-value bypass, so decode can see results that are not yet committed. The register file samples its write port on posedge clock and reads on negedge clock.

Parameters:
- DATA_WIDTH, 24, width of a register value.
- ADDR_WIDTH, 2, register index width; NUM_REGS = 2**ADDR_WIDTH.
- DEPTH, 4, queue entries; power of two, at least 2.
- ZERO_REG_DISCARD, 1, when 1, pushes targeting register 0 are accepted and dropped.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers a result.
- in_ready  out  1  queue can accept this cycle.
- in_reg  in  ADDR_WIDTH  destination register.
- in_data  in  DATA_WIDTH  result value.
- write_hold  in  1  when 1, draining pauses.
- reg_write  out  1  write-enable to register file (registered).
- write_reg  out  ADDR_WIDTH  write address (registered).
- write_data  out  DATA_WIDTH  write data (registered).
- count  out  log2(DEPTH)+1  current queue occupancy.
- pending  out  NUM_REGS  bit r=1 if a write to r is queued or on the write port.
- lookup_reg_1, lookup_reg_2  in  ADDR_WIDTH  bypass query addresses.
- bypass_hit_1, bypass_hit_2  out  1  queried register has a pending write.
- bypass_data_1, bypass_data_2  out  DATA_WIDTH  youngest pending value for the query.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clock, reset_n).
  - While reset_n=0: count=0, read/write pointers 0, reg_write=0, write_reg=0, write_data=0, pending=0, bypass_hit_*=0, bypass_data_*=0, in_ready=0.
  - First cycle after deassertion: in_ready=1.
  - Reset mid-operation discards all queued and in-flight writes; nothing reaches the register file.
- Push: occurs on a posedge with in_valid & in_ready.
  - in_ready = (count < DEPTH). It depends only on registered count, never on the same-cycle pop.
  - With ZERO_REG_DISCARD=1 and in_reg=0, the handshake completes but nothing is enqueued.
- Pop: occurs on a posedge with count>0 and write_hold=0.
  - Head entry is loaded into write_reg/write_data and reg_write=1 for the following cycle.
  - Otherwise reg_write=0 on the following cycle; write_reg/write_data hold their last values.
  - reg_write is never high for more than one cycle per entry.
- Simultaneous push and pop: count unchanged. A push into an empty queue is not popped in the same edge (no fall-through).
- Latency:
  - Push at edge N into an empty queue, write_hold=0: pop at N+1, reg_write=1 during cycle N+1..N+2, register file commits at edge N+2.
  - Sustained throughput is one write per cycle.
- Ordering: strict FIFO. Two writes to the same register commit in push order.
- Pointers wrap modulo DEPTH. Full is count==DEPTH and empty is count==0, with no pointer-equality ambiguity.
- pending: combinational from registered state. pending[r] is the OR of the valid queue entries with reg==r, OR (reg_write & write_reg==r). pending[0] is always 0 when ZERO_REG_DISCARD=1.
- Bypass: combinational.
  - hit_k = pending[lookup_reg_k].
  - data_k = youngest matching value: search the queue from tail-1 back to head, then the write-port stage.
  - data_k = 0 when there is no hit.
  - A push in the current cycle is not visible until after its edge.
- write_hold: may assert in any cycle. It freezes draining only; pushes continue until full.

Test Plan:
- Reset then single push: push (reg 2, 0x00ABCD) at edge 1 -> reg_write=1, write_reg=2, write_data=0x00ABCD during cycle after edge 2; pending=4'b0100 from edge 1 until edge 3; count 1 then 0.
- Fill and backpressure: write_hold=1, push regs 1,2,3,1 with data 0x11,0x22,0x33,0x44 -> count=4, in_ready=0, pending=4'b1110; a 5th in_valid is not accepted; bypass lookup 1 returns 0x44 with hit=1. Release hold -> four consecutive reg_write pulses in order 0x11,0x22,0x33,0x44, then reg_write=0.
- Simultaneous push/pop at count=2 with hold=0 -> count stays 2 over 3 cycles of streaming; output order matches push order exactly.
- Zero-register discard: push (reg 0, 0xFFFFFF) -> in_ready handshake completes, count stays 0, no reg_write pulse, pending[0]=0, bypass hit for lookup 0 is 0.
- Wrap-around: with DEPTH=4, stream 10 pushes (reg i%3+1, data i) with hold toggling every 3 cycles -> all 10 writes appear once, in order, with no loss or duplication.
- Async reset mid-stream: assert reset_n=0 with count=3 and reg_write=1, between edges -> reg_write, count, and pending go to 0 immediately; after release, in_ready=1 and no stale write appears.
